adder_sum_accumulator: RTL

Downstream stage of the 4-bit adder. Consumes the adder's 5-bit sum through a valid/ready handshake and adds COUNT consecutive sums into a wider accumulator. Presents the total, plus a sticky overflow flag, on an output valid/ready port. Frees the upstream operand source from tracking multi-sample totals.

---
 rtl/adder_sum_accumulator.sv | 91 +++++++++
 1 files changed

// File: rtl/adder_sum_accumulator.sv
// Accumulates COUNT consecutive adder sums into a wider total.
// Results go out over a valid/ready port with a sticky carry-out flag.
module adder_sum_accumulator #(
  parameter int IN_W  = 5,
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf,
  output logic             busy
);

  localparam int CW0 = $clog2(COUNT + 1);
  localparam int CW  = (CW0 < 1) ? 1 : CW0;
  localparam int SW  = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic [SW-1:0]    w_sum;
  logic [CW-1:0]    w_cnt_nxt;
  logic             w_last;

  assign in_ready  = (r_state != S_DONE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ACCUM);
  assign out_acc   = r_acc;
  assign out_ovf   = r_ovf;

  assign w_accept  = in_valid && in_ready;
  // Extra top bit of the sum is the carry out of the accumulator.
  assign w_sum     = {1'b0, r_acc} + SW'(in_sum);
  assign w_cnt_nxt = (r_state == S_IDLE) ? CW'(1) : r_cnt + CW'(1);
  assign w_last    = (w_cnt_nxt == CW'(COUNT));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_last ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        if (w_accept && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      if (r_state == S_IDLE) begin
        r_acc <= ACC_W'(in_sum);
        r_ovf <= 1'b0;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
        r_ovf <= r_ovf | w_sum[ACC_W];
      end
      r_cnt <= w_cnt_nxt;
    end
  end

endmodule
